// File: rtl/rdc_reset_sequencer.sv
// rdc_reset_sequencer: turns the board clock and asynchronous active-low reset
// into ordered per-domain resets. Reset assertion is asynchronous. Deassertion
// is synchronized and then released one domain at a time, HOLD_CYCLES apart.
// A four-phase software handshake re-runs the full assert/release sequence.
//
// Ports:
//   clk           sole clock
//   rst_n         asynchronous active-low reset
//   sw_rst_req    software reset request (level, synchronous to clk)
//   sw_rst_ack    software reset acknowledge (registered)
//   domain_rst_n  active-low reset per domain; bit 0 is released first (registered)
//   all_released  high when every domain is out of reset (registered)
module rdc_reset_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   all_released
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned IW = $clog2(NUM_DOMAINS + 1);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_RELEASE,
    ST_RUN,
    ST_SW_HOLD,
    ST_SW_ACK
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;

  // Reset-deassertion synchronizer: cleared asynchronously, shifts in ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // Sequencer FSM. RESET leaves on the edge where rst_sync rises (the stage
  // feeding it is already 1), so the first release lands HOLD_CYCLES after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RESET;
      cnt          <= '0;
      idx          <= '0;
      domain_rst_n <= '0;
      all_released <= 1'b0;
      sw_rst_ack   <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          if (sync_q[SYNC_STAGES-2] || rst_sync) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end
        end

        ST_RELEASE: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            cnt <= '0;
            idx <= idx + IW'(1);
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
              if (idx == IW'(i)) domain_rst_n[i] <= 1'b1;
            end
            if (idx == IW'(NUM_DOMAINS - 1)) begin
              all_released <= 1'b1;
              state        <= ST_RUN;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_RUN: begin
          if (sw_rst_req) begin
            domain_rst_n <= '0;
            all_released <= 1'b0;
            cnt          <= '0;
            state        <= ST_SW_HOLD;
          end
        end

        ST_SW_HOLD: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            sw_rst_ack <= 1'b1;
            state      <= ST_SW_ACK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_SW_ACK: begin
          // Domains stay in reset until the controller drops its request.
          if (!sw_rst_req) begin
            sw_rst_ack <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            state      <= ST_RELEASE;
          end
        end

        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rdc_reset_sequencer.sv
// Directed bench for rdc_reset_sequencer: default-parameter instance plus a
// NUM_DOMAINS=1 / HOLD_CYCLES=1 / SYNC_STAGES=3 corner instance sharing rst_n.
// Edge 0 is the first rising clk edge after rst_n goes high.
module tb_rdc_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic [2:0] domain_rst_n;
  logic       all_released;

  logic       c_req;
  logic       c_ack;
  logic [0:0] c_dom;
  logic       c_all;

  int checks;
  int errors;
  int e;

  rdc_reset_sequencer #(
    .SYNC_STAGES(2),
    .NUM_DOMAINS(3),
    .HOLD_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_ack  (sw_rst_ack),
    .domain_rst_n(domain_rst_n),
    .all_released(all_released)
  );

  rdc_reset_sequencer #(
    .SYNC_STAGES(3),
    .NUM_DOMAINS(1),
    .HOLD_CYCLES(1)
  ) dut_c (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_rst_req  (c_req),
    .sw_rst_ack  (c_ack),
    .domain_rst_n(c_dom),
    .all_released(c_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after edge n (samples taken 1 time unit past the edge).
  task automatic step_to(input int n);
    while (e < n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  // Raise rst_n between edges so the next edge is edge 0.
  task automatic release_reset();
    rst_n = 1'b1;
    e = -1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    e          = -1;
    rst_n      = 1'b0;
    sw_rst_req = 1'b0;
    c_req      = 1'b0;

    // Power-on with defaults
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("reset_dom", 8'(domain_rst_n), 8'h00);
    chk("reset_all", 8'(all_released), 8'h00);
    chk("reset_ack", 8'(sw_rst_ack), 8'h00);
    chk("reset_c_dom", 8'(c_dom), 8'h00);

    release_reset();
    step_to(2);
    chk("c_edge2_dom", 8'(c_dom), 8'h00);
    step_to(3);
    chk("c_edge3_dom", 8'(c_dom), 8'h01);
    chk("c_edge3_all", 8'(c_all), 8'h01);
    step_to(4);
    chk("po_e4", 8'(domain_rst_n), 8'h00);
    step_to(5);
    chk("po_e5", 8'(domain_rst_n), 8'h01);
    step_to(8);
    chk("po_e8", 8'(domain_rst_n), 8'h01);
    step_to(9);
    chk("po_e9", 8'(domain_rst_n), 8'h03);
    step_to(12);
    chk("po_e12_dom", 8'(domain_rst_n), 8'h03);
    chk("po_e12_all", 8'(all_released), 8'h00);
    step_to(13);
    chk("po_e13_dom", 8'(domain_rst_n), 8'h07);
    chk("po_e13_all", 8'(all_released), 8'h01);

    // Software reset: R = edge 14
    sw_rst_req = 1'b1;
    step_to(14);
    chk("sw_R_dom", 8'(domain_rst_n), 8'h00);
    chk("sw_R_all", 8'(all_released), 8'h00);
    chk("sw_R_ack", 8'(sw_rst_ack), 8'h00);
    step_to(17);
    chk("sw_R3_ack", 8'(sw_rst_ack), 8'h00);
    step_to(18);
    chk("sw_R4_ack", 8'(sw_rst_ack), 8'h01);
    step_to(20);
    chk("sw_hold_ack", 8'(sw_rst_ack), 8'h01);
    chk("sw_hold_dom", 8'(domain_rst_n), 8'h00);
    // Drop request; D = edge 21
    sw_rst_req = 1'b0;
    step_to(21);
    chk("sw_D_ack", 8'(sw_rst_ack), 8'h00);
    chk("sw_D_dom", 8'(domain_rst_n), 8'h00);
    step_to(24);
    chk("sw_D3", 8'(domain_rst_n), 8'h00);
    step_to(25);
    chk("sw_D4", 8'(domain_rst_n), 8'h01);
    step_to(29);
    chk("sw_D8", 8'(domain_rst_n), 8'h03);
    step_to(33);
    chk("sw_D12_dom", 8'(domain_rst_n), 8'h07);
    chk("sw_D12_all", 8'(all_released), 8'h01);

    // Reset mid-release, with the request held high throughout
    sw_rst_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_run_dom", 8'(domain_rst_n), 8'h00);
    chk("async_run_c", 8'(c_dom), 8'h00);
    @(posedge clk);
    #1;
    release_reset();
    step_to(5);
    chk("mid_e5", 8'(domain_rst_n), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_dom", 8'(domain_rst_n), 8'h00);
    chk("mid_async_all", 8'(all_released), 8'h00);
    @(posedge clk);
    #1;
    release_reset();
    step_to(4);
    chk("re_e4", 8'(domain_rst_n), 8'h00);
    step_to(5);
    chk("re_e5", 8'(domain_rst_n), 8'h01);
    step_to(9);
    chk("re_e9", 8'(domain_rst_n), 8'h03);
    step_to(13);
    chk("held_e13_dom", 8'(domain_rst_n), 8'h07);
    chk("held_e13_all", 8'(all_released), 8'h01);
    step_to(14);
    chk("held_e14_dom", 8'(domain_rst_n), 8'h00);
    chk("held_e14_all", 8'(all_released), 8'h00);
    step_to(18);
    chk("held_ack", 8'(sw_rst_ack), 8'h01);

    // Reset during SW_ACK
    step_to(19);
    #2;
    rst_n = 1'b0;
    #1;
    chk("swack_async_ack", 8'(sw_rst_ack), 8'h00);
    chk("swack_async_dom", 8'(domain_rst_n), 8'h00);
    sw_rst_req = 1'b0;
    @(posedge clk);
    #1;
    release_reset();
    step_to(1);
    chk("swack_re_ack", 8'(sw_rst_ack), 8'h00);
    step_to(5);
    chk("swack_re_e5", 8'(domain_rst_n), 8'h01);
    chk("swack_re_e5_ack", 8'(sw_rst_ack), 8'h00);
    step_to(13);
    chk("swack_re_e13_dom", 8'(domain_rst_n), 8'h07);
    chk("swack_re_e13_all", 8'(all_released), 8'h01);
    step_to(16);
    chk("swack_run_dom", 8'(domain_rst_n), 8'h07);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
